// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, operand
// forward selects, the bundle of pipeline-register controls and a match helper.
package hazard_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DWAIT = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_NORMAL = 9'b1_1111_0000;
    localparam pipe_ctl_t CTL_RESET  = 9'b0_0000_1111;

    // A source depends on a producer only if it is read, written and not x0.
    function automatic logic src_hit(input logic [4:0] src, input logic used,
                                     input logic [4:0] rd, input logic we);
        return used && we && (src != 5'd0) && (src == rd);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// controller (slave); the controller's FSM state is exposed for observation.
interface hazard_ctrl_if #(parameter int CNT_W = 32);

    // i_imem_ready / i_dmem_ready act as ready: a fetch or data access
    // completes in exactly the cycle its ready is high; there is no separate
    // valid, the request is implied by the PC (imem) or by i_mem_dmem_access.
    logic [4:0]       i_id_rs1_addr;
    logic [4:0]       i_id_rs2_addr;
    logic             i_id_rs1_used;
    logic             i_id_rs2_used;
    logic [4:0]       i_ex_rs1_addr;
    logic [4:0]       i_ex_rs2_addr;
    logic [4:0]       i_ex_rd_addr;
    logic             i_ex_reg_write;
    logic             i_ex_mem_to_reg;
    logic [4:0]       i_mem_rd_addr;
    logic             i_mem_reg_write;
    logic [4:0]       i_wb_rd_addr;
    logic             i_wb_reg_write;
    logic             i_ex_redirect;
    logic             i_imem_ready;
    logic             i_mem_dmem_access;
    logic             i_dmem_ready;
    logic             o_pc_en;
    logic             o_if_id_en;
    logic             o_id_ex_en;
    logic             o_ex_mem_en;
    logic             o_mem_wb_en;
    logic             o_if_id_flush;
    logic             o_id_ex_flush;
    logic             o_ex_mem_flush;
    logic             o_mem_wb_flush;
    logic [1:0]       o_fwd_a;
    logic [1:0]       o_fwd_b;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [1:0]       o_dbg_state;

    modport master (
        output i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
               i_ex_rs1_addr, i_ex_rs2_addr, i_ex_rd_addr, i_ex_reg_write,
               i_ex_mem_to_reg, i_mem_rd_addr, i_mem_reg_write, i_wb_rd_addr,
               i_wb_reg_write, i_ex_redirect, i_imem_ready, i_mem_dmem_access,
               i_dmem_ready,
        input  o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
               o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush,
               o_fwd_a, o_fwd_b, o_stall_cnt, o_dbg_state
    );

    modport slave (
        input  i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
               i_ex_rs1_addr, i_ex_rs2_addr, i_ex_rd_addr, i_ex_reg_write,
               i_ex_mem_to_reg, i_mem_rd_addr, i_mem_reg_write, i_wb_rd_addr,
               i_wb_reg_write, i_ex_redirect, i_imem_ready, i_mem_dmem_access,
               i_dmem_ready,
        output o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
               o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush,
               o_fwd_a, o_fwd_b, o_stall_cnt, o_dbg_state
    );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand bypass select for one EX source: the younger MEM producer wins over
// WB, and x0 is never bypassed.
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_we,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_we,
    output logic [1:0] o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (src_hit(i_src, 1'b1, i_mem_rd, i_mem_we)) begin
            o_sel = FWD_MEM;
        end else if (src_hit(i_src, 1'b1, i_wb_rd, i_wb_we)) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline: memory-wait and
// stale-fetch FSM, load-use/RAW stalls, redirect flushes and a stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    hazard_ctrl_if.slave bus
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [1:0]       fwd_a_raw, fwd_b_raw;
    logic             dmem_wait, load_use, raw_stall, id_stall;
    pipe_ctl_t        ctl;

    fwd_unit u_fwd_a (
        .i_src    (bus.i_ex_rs1_addr),
        .i_mem_rd (bus.i_mem_rd_addr),
        .i_mem_we (bus.i_mem_reg_write),
        .i_wb_rd  (bus.i_wb_rd_addr),
        .i_wb_we  (bus.i_wb_reg_write),
        .o_sel    (fwd_a_raw)
    );

    fwd_unit u_fwd_b (
        .i_src    (bus.i_ex_rs2_addr),
        .i_mem_rd (bus.i_mem_rd_addr),
        .i_mem_we (bus.i_mem_reg_write),
        .i_wb_rd  (bus.i_wb_rd_addr),
        .i_wb_we  (bus.i_wb_reg_write),
        .o_sel    (fwd_b_raw)
    );

    always_comb begin
        dmem_wait = bus.i_mem_dmem_access && !bus.i_dmem_ready;
        load_use  = bus.i_ex_mem_to_reg &&
                    (src_hit(bus.i_id_rs1_addr, bus.i_id_rs1_used, bus.i_ex_rd_addr, 1'b1) ||
                     src_hit(bus.i_id_rs2_addr, bus.i_id_rs2_used, bus.i_ex_rd_addr, 1'b1));
        // Without bypass paths any in-flight EX/MEM producer must drain first;
        // WB is safe because the regfile writes through to its read ports.
        raw_stall = !FWD_EN &&
                    (src_hit(bus.i_id_rs1_addr, bus.i_id_rs1_used, bus.i_ex_rd_addr,  bus.i_ex_reg_write)  ||
                     src_hit(bus.i_id_rs2_addr, bus.i_id_rs2_used, bus.i_ex_rd_addr,  bus.i_ex_reg_write)  ||
                     src_hit(bus.i_id_rs1_addr, bus.i_id_rs1_used, bus.i_mem_rd_addr, bus.i_mem_reg_write) ||
                     src_hit(bus.i_id_rs2_addr, bus.i_id_rs2_used, bus.i_mem_rd_addr, bus.i_mem_reg_write));
        id_stall  = load_use || raw_stall;
    end

    always_comb begin
        ctl     = CTL_NORMAL;
        state_d = state_q;
        case (state_q)
            ST_DROP: begin
                // PC already holds the redirect target; swallow the old fetch.
                ctl.pc_en       = 1'b0;
                ctl.if_id_flush = 1'b1;
                if (dmem_wait) begin
                    ctl.id_ex_en     = 1'b0;
                    ctl.ex_mem_en    = 1'b0;
                    ctl.mem_wb_flush = 1'b1;
                end
                if (bus.i_imem_ready) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (dmem_wait) begin
                    ctl.pc_en        = 1'b0;
                    ctl.if_id_en     = 1'b0;
                    ctl.id_ex_en     = 1'b0;
                    ctl.ex_mem_en    = 1'b0;
                    ctl.mem_wb_flush = 1'b1;
                    state_d          = ST_DWAIT;
                end else begin
                    state_d = ST_RUN;
                    if (bus.i_ex_redirect) begin
                        ctl.if_id_flush = 1'b1;
                        ctl.id_ex_flush = 1'b1;
                        if (!bus.i_imem_ready) begin
                            state_d = ST_DROP;
                        end
                    end else if (id_stall) begin
                        ctl.pc_en       = 1'b0;
                        ctl.if_id_en    = 1'b0;
                        ctl.id_ex_flush = 1'b1;
                    end else if (!bus.i_imem_ready) begin
                        ctl.pc_en       = 1'b0;
                        ctl.if_id_flush = 1'b1;
                    end
                end
            end
        endcase
        if (!i_rst_n) begin
            ctl = CTL_RESET;
        end
        stall_cnt_d = stall_cnt_q + CNT_W'(!ctl.pc_en);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.o_pc_en        = ctl.pc_en;
    assign bus.o_if_id_en     = ctl.if_id_en;
    assign bus.o_id_ex_en     = ctl.id_ex_en;
    assign bus.o_ex_mem_en    = ctl.ex_mem_en;
    assign bus.o_mem_wb_en    = ctl.mem_wb_en;
    assign bus.o_if_id_flush  = ctl.if_id_flush;
    assign bus.o_id_ex_flush  = ctl.id_ex_flush;
    assign bus.o_ex_mem_flush = ctl.ex_mem_flush;
    assign bus.o_mem_wb_flush = ctl.mem_wb_flush;
    assign bus.o_fwd_a        = (FWD_EN && i_rst_n) ? fwd_a_raw : FWD_RF;
    assign bus.o_fwd_b        = (FWD_EN && i_rst_n) ? fwd_b_raw : FWD_RF;
    assign bus.o_stall_cnt    = stall_cnt_q;
    assign bus.o_dbg_state    = state_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush/forward controller for the 5-stage pipeline.
- Sequences the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Decides on load-use hazards, EX-stage redirects, multi-cycle imem/dmem waits, and EX-operand forwarding.
- Contains a small FSM for memory waits and stale-fetch drop, plus a stall-cycle counter.

Parameters:
- CNT_W, 32: width of the stall-cycle counter.
- FWD_EN, 1: 1 = forwarding enabled; 0 = RAW hazards resolved by stalling only.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_id_rs1_addr, i_id_rs2_addr  in  5 each  source registers of the instruction in ID.
- i_id_rs1_used, i_id_rs2_used  in  1 each  ID instruction actually reads rs1/rs2.
- i_ex_rs1_addr, i_ex_rs2_addr  in  5 each  source registers of the instruction in EX.
- i_ex_rd_addr, i_ex_reg_write, i_ex_mem_to_reg  in  5/1/1  EX destination, writes a register, is a load.
- i_mem_rd_addr, i_mem_reg_write  in  5/1  MEM destination.
- i_wb_rd_addr, i_wb_reg_write  in  5/1  WB destination.
- i_ex_redirect  in  1  branch taken or jump resolved in EX; PC loads the target when o_pc_en=1.
- i_imem_ready  in  1  fetch response for the current PC is valid this cycle.
- i_mem_dmem_access  in  1  MEM instruction has ren or wen set.
- i_dmem_ready  in  1  dmem access completes this cycle.
- o_pc_en  out  1  PC update enable.
- o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en  out  1 each  pipeline register load enables.
- o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush  out  1 each  load NOP/bubble (reg_write=0, wen=0) instead of inputs.
- o_fwd_a, o_fwd_b  out  2 each  EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB writeback value.
- o_stall_cnt  out  CNT_W  cycles with o_pc_en=0 since reset; wraps modulo 2^CNT_W.

Behaviour:
- FSM states: RUN, DWAIT, DROP.
- Registered state: the FSM state and o_stall_cnt only. All other outputs are combinational from state and inputs.
- Reset (i_rst_n=0, asynchronous):
  - state=RUN, o_stall_cnt=0.
  - While held in reset: all *_en=0, all *_flush=1, o_pc_en=0, fwd=00.
- dmem wait:
  - Condition: i_mem_dmem_access=1 and i_dmem_ready=0, in RUN or DWAIT.
  - Response: PC, IF/ID, ID/EX, EX/MEM frozen (en=0, flush=0); MEM/WB en=1 with flush=1 (bubble).
  - Next state: DWAIT. DWAIT returns to RUN in the cycle i_dmem_ready=1; that cycle is a normal cycle.
  - Highest priority: overrides load-use and redirect. The redirect stays asserted because EX is held, and is acted on after the wait.
- Load-use (applies when not dmem-waiting):
  - Condition: i_ex_mem_to_reg=1, i_ex_rd_addr!=0, and it matches a used ID source.
  - Response: PC and IF/ID frozen; ID/EX flush=1; EX/MEM and MEM/WB advance.
- FWD_EN=0: also stall as for load-use when a used ID source (nonzero) matches EX rd with i_ex_reg_write=1, or MEM rd with i_mem_reg_write=1. WB is not checked; the regfile bypasses writes internally.
- Redirect (not dmem-waiting):
  - Response: o_pc_en=1; IF/ID flush=1 and ID/EX flush=1.
  - Redirect overrides the load-use stall in the same cycle.
  - If i_imem_ready=0 in that cycle, next state is DROP.
- DROP:
  - The stale fetch is still outstanding.
  - o_pc_en=0 (PC holds the target); IF/ID flush=1 every cycle.
  - Older stages advance normally, subject to dmem wait.
  - Returns to RUN the cycle after i_imem_ready=1; that response is discarded.
- imem wait (RUN, i_imem_ready=0, no redirect, no other stall):
  - o_pc_en=0; IF/ID en=1 with flush=1 (bubble).
  - ID/EX and later advance.
- Normal cycle: all en=1, all flush=0.
- Forwarding, per operand, when FWD_EN=1:
  - 01 if i_mem_reg_write=1, i_mem_rd_addr!=0 and it equals the EX source.
  - Else 10 if the same test against WB passes.
  - Else 00.
  - MEM has priority over WB. x0 is never forwarded. When FWD_EN=0, fwd=00 always.
- Stall counter: o_stall_cnt increments in every cycle with o_pc_en=0 outside reset.

Decomposition:
- Shared package (hazard_pkg): state encoding (RUN=2'd0, DWAIT=2'd1, DROP=2'd2) and fwd select constants (FWD_RF, FWD_MEM, FWD_WB).
- One natural sub-module: fwd_unit (purely combinational source-vs-destination match for one operand), instantiated twice.

Test Plan:
- Load-use: EX `lw x5` (mem_to_reg=1, rd=5); ID `add x6,x5,x1` with rs1_used=1 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1. Next cycle EX has rs1=5 and WB rd=5 → o_fwd_a=10; o_stall_cnt=1.
- Double hazard: MEM rd=3 with reg_write, WB rd=3 with reg_write; EX rs2=3 → o_fwd_b=01. Same with rd=0 → o_fwd_b=00.
- dmem wait: i_mem_dmem_access=1, i_dmem_ready=0 for 3 cycles, with i_ex_redirect=1 held → 3 cycles of frozen PC..EX/MEM, mem_wb_flush=1, state DWAIT. The 4th cycle (ready=1) does the redirect: pc_en=1, if_id_flush=id_ex_flush=1. o_stall_cnt=3.
- Redirect during imem miss: i_ex_redirect=1, i_imem_ready=0 → DROP. Keep ready=0 for 2 more cycles, then 1 → pc_en=0 and if_id_flush=1 through the ready cycle; RUN the following cycle.
- FWD_EN=0: EX rd=7 with reg_write, ID rs2=7 used → stall with id_ex_flush=1. The stall repeats while MEM holds rd=7, then releases when rd=7 reaches WB.
- Async reset: assert i_rst_n=0 mid-DWAIT (between clock edges) → immediately all flush=1, all en=0. After release: state RUN, o_stall_cnt=0.
